fir_mac_serial: RTL and testbench

//   Parametrised time-multiplexed FIR low-pass filter: one shared multiplier-accumulator

---
 rtl/fir_mac_serial_if.sv | 26 ++
 rtl/fir_mac_serial.sv | 113 +++++++++++
 tb/tb_fir_mac_serial.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_serial_if.sv
// fir_mac_serial_if: sample intake, coefficient write and result bus of the serial FIR
interface fir_mac_serial_if #(
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int AW     = 7
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     coef_wr_en;
    logic [AW-1:0]            coef_wr_addr;
    logic signed [COEF_W-1:0] coef_wr_data;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;

    modport master (
        output in_valid, in_data, coef_wr_en, coef_wr_addr, coef_wr_data,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, coef_wr_en, coef_wr_addr, coef_wr_data,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/fir_mac_serial.sv
// fir_mac_serial: time-multiplexed FIR, one MAC walks all taps per sample, rounds and saturates
module fir_mac_serial #(
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int TAPS   = 128,
    parameter int SHIFT  = 8
) (
    input logic              clk,
    input logic              rst_n,
    fir_mac_serial_if.slave  bus
);
    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + AW;
    localparam logic [AW-1:0]         LAST = AW'(TAPS - 1);
    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [ACC_W:0] DMAX = (ACC_W+1)'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] DMIN = ~DMAX;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                   state, state_nxt;
    logic signed [DATA_W-1:0] delay [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [AW-1:0]            index;
    logic                     accept;
    logic                     coef_we;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]    rnd_sum;
    logic signed [ACC_W:0]    rnd_val;
    logic                     sat_hi;
    logic                     sat_lo;
    logic signed [DATA_W-1:0] result;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // next state; intake and coefficient writes are only honoured while idle
    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        coef_we      = 1'b0;
        bus.in_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                coef_we      = bus.coef_wr_en;
                state_nxt    = bus.in_valid ? CALC : IDLE;
            end
            CALC:    state_nxt = (index == LAST) ? DONE : CALC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tap product, round-half-up scaling and clipping to the output range
    always_comb begin
        prod    = PROD_W'(coef[index]) * PROD_W'(delay[index]);
        rnd_sum = {acc[ACC_W-1], acc} + RND;
        rnd_val = rnd_sum >>> SHIFT;
        sat_hi  = rnd_val > DMAX;
        sat_lo  = rnd_val < DMIN;
        result  = sat_hi ? DMAX[DATA_W-1:0] : sat_lo ? DMIN[DATA_W-1:0] : rnd_val[DATA_W-1:0];
    end

    // coefficient file; a write on the accept edge is seen by that sample's pass
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= '0;
        end else if (coef_we) begin
            coef[bus.coef_wr_addr] <= bus.coef_wr_data;
        end

    // delay line shifts once per accepted sample
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) delay[i] <= '0;
        end else if (accept) begin
            for (int i = 1; i < TAPS; i++) delay[i] <= delay[i-1];
            delay[0] <= bus.in_data;
        end

    // accumulator and tap index: cleared on accept, one tap per CALC cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc   <= '0;
            index <= '0;
        end else if (accept) begin
            acc   <= '0;
            index <= '0;
        end else if (state == CALC) begin
            acc   <= acc + ACC_W'(prod);
            index <= index + AW'(1);
        end

    // result registers change only in DONE; out_valid is a single-cycle pulse
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
        end else begin
            bus.out_valid <= state == DONE;
            if (state == DONE) begin
                bus.out_data <= result;
                bus.out_sat  <= sat_hi | sat_lo;
            end
        end
endmodule

// File: tb/tb_fir_mac_serial.sv
// tb_fir_mac_serial: randomized and directed checks of fir_mac_serial against an arithmetic model
module tb_fir_mac_serial;
    localparam int DATA_W = 18;
    localparam int COEF_W = 18;
    localparam int TAPS   = 128;
    localparam int SHIFT  = 8;
    localparam int AW     = $clog2(TAPS);
    localparam longint DMAX = (64'sd1 <<< (DATA_W - 1)) - 1;
    localparam longint DMIN = -DMAX - 1;

    logic   clk = 1'b0;
    logic   rst_n = 1'b1;
    int     n_vec = 0;
    int     n_err = 0;
    longint m_coef [TAPS];
    longint m_dly [TAPS];

    fir_mac_serial_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .AW(AW)) bus ();

    fir_mac_serial #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .SHIFT(SHIFT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // model: convolution of the last TAPS accepted samples, then round and clip
    task automatic m_clear;
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = 0;
            m_dly[i]  = 0;
        end
    endtask

    task automatic m_accept(input longint d, output longint q, output bit s);
        longint acc;
        longint r;
        acc = 0;
        for (int i = TAPS - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
        m_dly[0] = d;
        for (int i = 0; i < TAPS; i++) acc += m_coef[i] * m_dly[i];
        r = (acc + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
        s = (r > DMAX) || (r < DMIN);
        q = (r > DMAX) ? DMAX : (r < DMIN) ? DMIN : r;
    endtask

    task automatic do_reset;
        bus.in_valid   = 1'b0;
        bus.coef_wr_en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_clear();
    endtask

    task automatic wcoef(input int a, input longint c);
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_addr = AW'(a);
        bus.coef_wr_data = COEF_W'(c);
        @(posedge clk);
        #1 bus.coef_wr_en = 1'b0;
        m_coef[a] = c;
    endtask

    // one sample end to end; wa writes a coefficient on the accept edge, wc tries during CALC
    task automatic send(input longint d, input bit wa, input bit wc, input int a, input longint c,
                        output longint oq, output bit os, output longint eq, output bit es,
                        output int lat, output bit ov2);
        int g;
        g = 0;
        while (!bus.in_ready && g < 400) begin
            @(posedge clk);
            #1 g++;
        end
        bus.in_valid     = 1'b1;
        bus.in_data      = DATA_W'(d);
        bus.coef_wr_en   = wa;
        bus.coef_wr_addr = AW'(a);
        bus.coef_wr_data = COEF_W'(c);
        if (wa) m_coef[a] = c;
        m_accept(d, eq, es);
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.coef_wr_en = wc;
        lat = 0;
        while (!bus.out_valid && lat < 400) begin
            @(posedge clk);
            #1 lat++;
            if (lat == 8) bus.coef_wr_en = 1'b0;
        end
        bus.coef_wr_en = 1'b0;
        oq = longint'(bus.out_data);
        os = bus.out_sat;
        @(posedge clk);
        #1 ov2 = bus.out_valid;
    endtask

    task automatic test_reset;
        longint oq, eq;
        bit os, es, ov2;
        int lat, pulses;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL por_in_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL por_out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_data !== '0) begin n_err++; $display("FAIL por_out_data: got %0d want 0", bus.out_data); end
        n_vec++; if (bus.out_sat !== 1'b0) begin n_err++; $display("FAIL por_out_sat: got %b want 0", bus.out_sat); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_clear();
        for (int k = 0; k < 4; k++) wcoef(k, 256);
        send(1000, 0, 0, 0, 0, oq, os, eq, es, lat, ov2);
        n_vec++; if (oq !== 1000 || os !== 1'b0) begin n_err++; $display("FAIL rst_pre1: got %0d/%b want 1000/0", oq, os); end
        send(2000, 0, 0, 0, 0, oq, os, eq, es, lat, ov2);
        n_vec++; if (oq !== 3000) begin n_err++; $display("FAIL rst_pre2: got %0d want 3000", oq); end
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(3000);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_data !== '0) begin n_err++; $display("FAIL rst_mid_out_data: got %0d want 0", bus.out_data); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_clear();
        pulses = 0;
        for (int i = 0; i < TAPS + 10; i++) begin
            @(posedge clk);
            #1 if (bus.out_valid) pulses++;
        end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL rst_aborted_output: got %0d pulses want 0", pulses); end
        for (int k = 0; k < 4; k++) wcoef(k, 256);
        send(700, 0, 0, 0, 0, oq, os, eq, es, lat, ov2);
        n_vec++; if (oq !== 700 || oq !== eq) begin n_err++; $display("FAIL rst_clean_delay: got %0d want 700", oq); end
    endtask

    task automatic test_impulse;
        longint oq, eq, want;
        bit os, es, ov2;
        int lat;
        do_reset();
        for (int k = 0; k < 8; k++) wcoef(k, k + 1);
        for (int i = 0; i < 10; i++) begin
            send(i == 0 ? 256 : 0, 0, 0, 0, 0, oq, os, eq, es, lat, ov2);
            want = (i < 8) ? longint'(i + 1) : 0;
            n_vec++; if (oq !== want) begin n_err++; $display("FAIL impulse[%0d]: got %0d want %0d", i, oq, want); end
            n_vec++; if (lat !== TAPS + 1) begin n_err++; $display("FAIL impulse_latency[%0d]: got %0d want %0d", i, lat, TAPS + 1); end
            n_vec++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL impulse_pulse[%0d]: out_valid got %b want 0", i, ov2); end
        end
    endtask

    task automatic test_rounding;
        longint oq, eq;
        bit os, es, ov2;
        int lat;
        longint din [3] = '{128, -128, -129};
        longint want [3] = '{1, 0, -1};
        do_reset();
        wcoef(0, 1);
        for (int i = 0; i < 3; i++) begin
            send(din[i], 0, 0, 0, 0, oq, os, eq, es, lat, ov2);
            n_vec++; if (oq !== want[i] || os !== 1'b0) begin n_err++; $display("FAIL round[%0d]: got %0d/%b want %0d/0", i, oq, os, want[i]); end
        end
    endtask

    task automatic test_saturation;
        longint oq, eq;
        bit os, es, ov2;
        int lat;
        do_reset();
        for (int k = 0; k < TAPS; k++) wcoef(k, (64'sd1 <<< (COEF_W - 1)) - 1);
        for (int i = 0; i < 2; i++) begin
            send(DMAX, 0, 0, 0, 0, oq, os, eq, es, lat, ov2);
            n_vec++; if (oq !== 131071 || os !== 1'b1) begin n_err++; $display("FAIL sat_hi[%0d]: got %0d/%b want 131071/1", i, oq, os); end
        end
        for (int i = 0; i < 3; i++) begin
            send(DMIN, 0, 0, 0, 0, oq, os, eq, es, lat, ov2);
            n_vec++; if (oq !== eq || os !== es) begin n_err++; $display("FAIL sat_model[%0d]: got %0d/%b want %0d/%b", i, oq, os, eq, es); end
        end
        n_vec++; if (oq !== -131072 || os !== 1'b1) begin n_err++; $display("FAIL sat_lo: got %0d/%b want -131072/1", oq, os); end
    endtask

    task automatic test_back_to_back;
        longint eq_q[$];
        bit     es_q[$];
        longint q, d;
        bit     s, rdy;
        int     n_acc, n_out, last, cyc;
        n_acc = 0; n_out = 0; last = -1; cyc = 0;
        do_reset();
        for (int i = 0; i < 16; i++) wcoef(int'($urandom_range(TAPS - 1)), longint'($urandom_range(2048)) - 1024);
        d = longint'($urandom_range(8192)) - 4096;
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(d);
        while ((n_acc < 12 || n_out < n_acc) && cyc < 3000) begin
            @(negedge clk);
            rdy = bus.in_ready;
            if (bus.out_valid) begin
                n_vec++;
                if (eq_q.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra_output: got %0d with none pending", bus.out_data);
                end else begin
                    q = eq_q.pop_front();
                    s = es_q.pop_front();
                    if (longint'(bus.out_data) !== q || bus.out_sat !== s) begin
                        n_err++; $display("FAIL b2b_out[%0d]: got %0d/%b want %0d/%b", n_out, bus.out_data, bus.out_sat, q, s);
                    end
                end
                n_out++;
            end
            @(posedge clk);
            #1;
            if (rdy && bus.in_valid) begin
                m_accept(d, q, s);
                eq_q.push_back(q);
                es_q.push_back(s);
                if (last >= 0) begin
                    n_vec++; if (cyc - last !== TAPS + 2) begin n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", n_acc, cyc - last, TAPS + 2); end
                end
                last = cyc;
                n_acc++;
                if (n_acc == 12) bus.in_valid = 1'b0;
                d = ($urandom_range(3) == 0) ? longint'($urandom_range(262143)) - 131072 : longint'($urandom_range(8192)) - 4096;
                bus.in_data = DATA_W'(d);
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_vec++; if (n_out !== 12 || n_acc !== 12) begin n_err++; $display("FAIL b2b_count: got %0d out %0d in want 12/12", n_out, n_acc); end
    endtask

    task automatic test_coef_gating;
        longint oq, eq;
        bit os, es, ov2;
        int lat;
        do_reset();
        wcoef(0, 256);
        send(100, 0, 1, 0, 1000, oq, os, eq, es, lat, ov2);
        n_vec++; if (oq !== 100) begin n_err++; $display("FAIL gate_calc_write: got %0d want 100", oq); end
        send(50, 0, 0, 0, 0, oq, os, eq, es, lat, ov2);
        n_vec++; if (oq !== 50) begin n_err++; $display("FAIL gate_file_kept: got %0d want 50", oq); end
        send(40, 1, 0, 0, 512, oq, os, eq, es, lat, ov2);
        n_vec++; if (oq !== 80 || oq !== eq) begin n_err++; $display("FAIL gate_accept_write: got %0d want 80", oq); end
        send(10, 0, 0, 0, 0, oq, os, eq, es, lat, ov2);
        n_vec++; if (oq !== 20) begin n_err++; $display("FAIL gate_accept_stored: got %0d want 20", oq); end
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.coef_wr_en   = 1'b0;
        bus.coef_wr_addr = '0;
        bus.coef_wr_data = '0;
        test_reset();
        test_impulse();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_coef_gating();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog");
    end
endmodule
